// File: rtl/multicycle_controller.sv
// Control unit for a multicycle ARM-subset datapath: FSM sequencing,
// ALU decode, condition evaluation with latched CondEx, and the flags register.
module multicycle_controller (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:12] Instr,
  input  logic [3:0]   ALUFlags,
  output logic         PCWrite,
  output logic         MemWrite,
  output logic         RegWrite,
  output logic         IRWrite,
  output logic         AdrSrc,
  output logic [1:0]   ResultSrc,
  output logic [1:0]   ALUSrcA,
  output logic [1:0]   ALUSrcB,
  output logic [1:0]   ImmSrc,
  output logic [1:0]   RegSrc,
  output logic [1:0]   ALUControl
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXECUTER, EXECUTEI, ALUWB, BRANCH
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic       cond_ex_q, cond_ex_d;

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] unused_rn;

  assign cond      = Instr[31:28];
  assign op        = Instr[27:26];
  assign funct     = Instr[25:20];
  assign rd        = Instr[15:12];
  assign unused_rn = Instr[19:16];

  // Flags are {N,Z,C,V}.
  function automatic logic cond_check(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'b0000: cond_check = z;
      4'b0001: cond_check = ~z;
      4'b0010: cond_check = cf;
      4'b0011: cond_check = ~cf;
      4'b0100: cond_check = n;
      4'b0101: cond_check = ~n;
      4'b0110: cond_check = v;
      4'b0111: cond_check = ~v;
      4'b1000: cond_check = cf & ~z;
      4'b1001: cond_check = ~cf | z;
      4'b1010: cond_check = (n == v);
      4'b1011: cond_check = (n != v);
      4'b1100: cond_check = ~z & (n == v);
      4'b1101: cond_check = z | (n != v);
      4'b1110: cond_check = 1'b1;
      default: cond_check = 1'b0;
    endcase
  endfunction

  logic [1:0] alu_dec;
  logic       no_write;
  logic       arith;
  logic       is_exec;

  always_comb begin
    alu_dec  = 2'b00;
    no_write = 1'b0;
    arith    = 1'b0;
    case (funct[4:1])
      4'b0100: begin alu_dec = 2'b00; arith = 1'b1; end
      4'b0010: begin alu_dec = 2'b01; arith = 1'b1; end
      4'b0000: alu_dec = 2'b10;
      4'b1100: alu_dec = 2'b11;
      4'b1010: begin alu_dec = 2'b01; arith = 1'b1; no_write = 1'b1; end
      default: alu_dec = 2'b00;
    endcase
  end

  assign is_exec = (state_q == EXECUTER) || (state_q == EXECUTEI);

  // CondEx is frozen at DECODE so an instruction's own flag update cannot gate its writeback.
  always_comb begin
    cond_ex_d = cond_ex_q;
    flags_d   = flags_q;
    if (state_q == DECODE)
      cond_ex_d = cond_check(cond, flags_q);
    if (is_exec && cond_ex_q && funct[0]) begin
      flags_d[3:2] = ALUFlags[3:2];
      if (arith)
        flags_d[1:0] = ALUFlags[1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= FETCH;
      flags_q   <= 4'b0000;
      cond_ex_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      flags_q   <= flags_d;
      cond_ex_q <= cond_ex_d;
    end
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (op)
          2'b01:   state_d = MEMADR;
          2'b00:   state_d = funct[5] ? EXECUTEI : EXECUTER;
          2'b10:   state_d = BRANCH;
          default: state_d = FETCH;
        endcase
      end
      MEMADR:   state_d = funct[0] ? MEMRD : MEMWR;
      MEMRD:    state_d = MEMWB;
      EXECUTER: state_d = ALUWB;
      EXECUTEI: state_d = ALUWB;
      default:  state_d = FETCH;
    endcase
  end

  always_comb begin
    PCWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    IRWrite    = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUControl = 2'b00;
    case (state_q)
      FETCH: begin
        IRWrite   = 1'b1;
        PCWrite   = 1'b1;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
      end
      MEMADR: ALUSrcB = 2'b01;
      MEMRD:  AdrSrc = 1'b1;
      MEMWR: begin
        AdrSrc   = 1'b1;
        MemWrite = cond_ex_q;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = cond_ex_q;
        PCWrite   = cond_ex_q && (rd == 4'hF);
      end
      EXECUTER: ALUControl = alu_dec;
      EXECUTEI: begin
        ALUSrcB    = 2'b01;
        ALUControl = alu_dec;
      end
      ALUWB: begin
        RegWrite = cond_ex_q & ~no_write;
        PCWrite  = cond_ex_q & ~no_write & (rd == 4'hF);
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = cond_ex_q;
      end
      default: ;
    endcase
    // Write enables drop the moment reset asserts, without waiting for a clock.
    if (!reset) begin
      PCWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      IRWrite  = 1'b0;
    end
  end

  assign ImmSrc = op;
  assign RegSrc = {op == 2'b01, op == 2'b10};

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed, table-driven bench for multicycle_controller: one record per clock
// cycle with the instruction, ALU flags and hand-computed control outputs.
module tb_multicycle_controller;

  logic         clk;
  logic         reset;
  logic [31:12] Instr;
  logic [3:0]   ALUFlags;
  logic         PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
  logic [1:0]   ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl;

  multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .Instr      (Instr),
    .ALUFlags   (ALUFlags),
    .PCWrite    (PCWrite),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .IRWrite    (IRWrite),
    .AdrSrc     (AdrSrc),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc),
    .ALUControl (ALUControl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed as {PCWrite,MemWrite,RegWrite,IRWrite,AdrSrc,ResultSrc,ALUSrcA,ALUSrcB,ALUControl}
  localparam logic [12:0] S_F    = 13'b1_0_0_1_0_10_01_10_00;
  localparam logic [12:0] S_D    = 13'b0_0_0_0_0_10_01_10_00;
  localparam logic [12:0] S_MA   = 13'b0_0_0_0_0_00_00_01_00;
  localparam logic [12:0] S_MR   = 13'b0_0_0_0_1_00_00_00_00;
  localparam logic [12:0] S_MB1  = 13'b0_0_1_0_0_01_00_00_00;
  localparam logic [12:0] S_MB0  = 13'b0_0_0_0_0_01_00_00_00;
  localparam logic [12:0] S_MW1  = 13'b0_1_0_0_1_00_00_00_00;
  localparam logic [12:0] S_MW0  = 13'b0_0_0_0_1_00_00_00_00;
  localparam logic [12:0] S_ERAD = 13'b0_0_0_0_0_00_00_00_00;
  localparam logic [12:0] S_ERCM = 13'b0_0_0_0_0_00_00_00_01;
  localparam logic [12:0] S_EISB = 13'b0_0_0_0_0_00_00_01_01;
  localparam logic [12:0] S_EIAN = 13'b0_0_0_0_0_00_00_01_10;
  localparam logic [12:0] S_WB1  = 13'b0_0_1_0_0_00_00_00_00;
  localparam logic [12:0] S_WB0  = 13'b0_0_0_0_0_00_00_00_00;
  localparam logic [12:0] S_WBPC = 13'b1_0_1_0_0_00_00_00_00;
  localparam logic [12:0] S_BR1  = 13'b1_0_0_0_0_10_00_01_00;
  localparam logic [12:0] S_BR0  = 13'b0_0_0_0_0_10_00_01_00;
  localparam logic [12:0] S_RST  = 13'b0_0_0_0_0_10_01_10_00;

  typedef struct {
    logic [31:0] instr;
    logic [3:0]  alu;
    logic [12:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic add(input logic [31:0] instr, input logic [3:0] alu, input logic [12:0] exp);
    vec_t v;
    v.instr = instr;
    v.alu   = alu;
    v.exp   = exp;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] instr, input logic [12:0] exp);
    logic [16:0] act, req;
    logic [1:0]  op;
    op  = instr[27:26];
    act = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB,
           ALUControl, ImmSrc, RegSrc};
    req = {exp, op, op == 2'b01, op == 2'b10};
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s instr=%h: got %b required %b", name, instr, act, req);
    end
  endtask

  task automatic step(input string name, input logic [31:0] instr, input logic [3:0] alu,
                      input logic [12:0] exp);
    @(negedge clk);
    Instr    = instr[31:12];
    ALUFlags = alu;
    #1;
    check(name, instr, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // ALUFlags default to 1111 outside EXECUTE so stray flag writes get noticed.
    add(32'hE0821003, 4'hF, S_F);  add(32'hE0821003, 4'hF, S_D);
    add(32'hE0821003, 4'hF, S_ERAD); add(32'hE0821003, 4'hF, S_WB1);
    add(32'hE5912004, 4'hF, S_F);  add(32'hE5912004, 4'hF, S_D);
    add(32'hE5912004, 4'hF, S_MA); add(32'hE5912004, 4'hF, S_MR);
    add(32'hE5912004, 4'hF, S_MB1);
    add(32'hE5812004, 4'hF, S_F);  add(32'hE5812004, 4'hF, S_D);
    add(32'hE5812004, 4'hF, S_MA); add(32'hE5812004, 4'hF, S_MW1);
    add(32'hE2500001, 4'hF, S_F);  add(32'hE2500001, 4'hF, S_D);
    add(32'hE2500001, 4'h4, S_EISB); add(32'hE2500001, 4'hF, S_WB1);
    add(32'h0A000002, 4'hF, S_F);  add(32'h0A000002, 4'hF, S_D);
    add(32'h0A000002, 4'hF, S_BR1);
    add(32'h11500000, 4'hF, S_F);  add(32'h11500000, 4'hF, S_D);
    add(32'h11500000, 4'h0, S_ERCM); add(32'h11500000, 4'hF, S_WB0);
    add(32'h0A000002, 4'hF, S_F);  add(32'h0A000002, 4'hF, S_D);
    add(32'h0A000002, 4'hF, S_BR1);
    add(32'hE2500001, 4'hF, S_F);  add(32'hE2500001, 4'hF, S_D);
    add(32'hE2500001, 4'h0, S_EISB); add(32'hE2500001, 4'hF, S_WB1);
    add(32'h0A000002, 4'hF, S_F);  add(32'h0A000002, 4'hF, S_D);
    add(32'h0A000002, 4'hF, S_BR0);
    add(32'hE082F003, 4'hF, S_F);  add(32'hE082F003, 4'hF, S_D);
    add(32'hE082F003, 4'hF, S_ERAD); add(32'hE082F003, 4'hF, S_WBPC);
    add(32'hEC000000, 4'hF, S_F);  add(32'hEC000000, 4'hF, S_D);
    add(32'h05912004, 4'hF, S_F);  add(32'h05912004, 4'hF, S_D);
    add(32'h05912004, 4'hF, S_MA); add(32'h05912004, 4'hF, S_MR);
    add(32'h05912004, 4'hF, S_MB0);
    add(32'h05812004, 4'hF, S_F);  add(32'h05812004, 4'hF, S_D);
    add(32'h05812004, 4'hF, S_MA); add(32'h05812004, 4'hF, S_MW0);
    add(32'h02500001, 4'hF, S_F);  add(32'h02500001, 4'hF, S_D);
    add(32'h02500001, 4'h4, S_EISB); add(32'h02500001, 4'hF, S_WB0);
    add(32'h0A000002, 4'hF, S_F);  add(32'h0A000002, 4'hF, S_D);
    add(32'h0A000002, 4'hF, S_BR0);
    add(32'h12500001, 4'hF, S_F);  add(32'h12500001, 4'hF, S_D);
    add(32'h12500001, 4'h4, S_EISB); add(32'h12500001, 4'hF, S_WB1);
    add(32'h0A000002, 4'hF, S_F);  add(32'h0A000002, 4'hF, S_D);
    add(32'h0A000002, 4'hF, S_BR1);
    add(32'hE2100000, 4'hF, S_F);  add(32'hE2100000, 4'hF, S_D);
    add(32'hE2100000, 4'h7, S_EIAN); add(32'hE2100000, 4'hF, S_WB1);
    add(32'h2A000002, 4'hF, S_F);  add(32'h2A000002, 4'hF, S_D);
    add(32'h2A000002, 4'hF, S_BR0);

    reset    = 1'b0;
    Instr    = 20'hE5812;
    ALUFlags = 4'hF;
    #1;
    check("reset_hold", 32'hE5812004, S_RST);
    repeat (2) @(negedge clk);
    #1;
    check("reset_hold_clocked", 32'hE5812004, S_RST);

    @(negedge clk);
    reset = 1'b1;
    Instr = 20'hE0821;
    #1;
    check("first_fetch", 32'hE0821003, S_F);
    for (int i = 1; i < vecs.size(); i++)
      step($sformatf("vec%0d", i), vecs[i].instr, vecs[i].alu, vecs[i].exp);

    // Flags now hold Z=1; reset in the middle of a store must kill MemWrite at once.
    step("str_fetch", 32'hE5812004, 4'hF, S_F);
    step("str_decode", 32'hE5812004, 4'hF, S_D);
    step("str_memadr", 32'hE5812004, 4'hF, S_MA);
    step("str_memwr", 32'hE5812004, 4'hF, S_MW1);
    #2;
    reset = 1'b0;
    #1;
    check("reset_mid_memwr", 32'hE5812004, S_MW0 & 13'b0_0_0_0_0_00_00_00_00 | S_RST);
    @(negedge clk);
    reset = 1'b1;
    Instr = 20'h0A000;
    #1;
    check("fetch_after_reset", 32'h0A000002, S_F);
    step("beq_decode", 32'h0A000002, 4'hF, S_D);
    step("beq_flags_cleared", 32'h0A000002, 4'hF, S_BR0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have no parameters; one clock; reset is asynchronous and active-low.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 Instr  in  20  Instr[31:12] from registered instruction: Cond[31:28], Op[27:26], Funct[25:20], Rd[15:12].
REQ-005 ALUFlags  in  4  {N,Z,C,V} from ALU, current cycle.
REQ-006 PCWrite  out  1  PC register enable.
REQ-007 MemWrite  out  1  data memory write enable.
REQ-008 RegWrite  out  1  register file write enable.
REQ-009 IRWrite  out  1  instruction register enable.
REQ-010 AdrSrc  out  1  memory address select: 0=PC, 1=ALU result register.
REQ-011 ResultSrc  out  2  00=ALUOut reg, 01=Data reg, 10=ALUResult direct.
REQ-012 ALUSrcA  out  2  00=RD1 reg, 01=PC.
REQ-013 ALUSrcB  out  2  00=RD2 reg, 01=ExtImm, 10=constant 4.
REQ-014 ImmSrc  out  2  extender mode; equals Op.
REQ-015 RegSrc  out  2  [0]=(Op==10), [1]=(Op==01).
REQ-016 ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR.

Function
REQ-017 FSM states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH; one transition per clk.
REQ-018 Transitions: FETCH->DECODE; DECODE: Op=01->MEMADR, Op=00&Funct[5]=0->EXECUTER, Op=00&Funct[5]=1->EXECUTEI, Op=10->BRANCH, Op=11->FETCH; MEMADR: Funct[0]=1->MEMRD else MEMWR; MEMRD->MEMWB; EXECUTER/EXECUTEI->ALUWB; MEMWB, MEMWR, ALUWB, BRANCH->FETCH.
REQ-019 FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=01, ALUSrcB=10, ADD, ResultSrc=10, PCWrite=1 unconditionally.
REQ-020 DECODE: ALUSrcA=01, ALUSrcB=10, ADD, ResultSrc=10; no write enables.
REQ-021 MEMADR: ALUSrcA=00, ALUSrcB=01, ADD. MEMRD: AdrSrc=1, ResultSrc=00. MEMWR: AdrSrc=1, MemWrite=CondEx.
REQ-022 MEMWB: ResultSrc=01, RegWrite=CondEx. ALUWB: ResultSrc=00, RegWrite=CondEx&~NoWrite.
REQ-023 EXECUTER: ALUSrcA=00, ALUSrcB=00; EXECUTEI: ALUSrcA=00, ALUSrcB=01; both use ALU decode.
REQ-024 BRANCH: ALUSrcA=00, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=CondEx.
REQ-025 ALU decode, Funct[4:1]: 0100->00, 0010->01, 0000->10, 1100->11, 1010 (CMP)->01 with NoWrite=1; other codes->00; non-execute states->00.
REQ-026 Rd=15 in MEMWB or ALUWB with RegWrite asserted SHALL also assert PCWrite.
REQ-027 Flags register {N,Z,C,V} written on EXECUTER/EXECUTEI edge only when CondEx=1 and Funct[0]=1: NZ always; CV only for ADD/SUB/CMP.
REQ-028 CondEx: EQ Z, NE ~Z, CS C, CC ~C, MI N, PL ~N, VS V, VC ~V, HI C&~Z, LS ~C|Z, GE N==V, LT N!=V, GT ~Z&(N==V), LE Z|(N!=V), AL 1, 1111 0.
REQ-029 CondEx SHALL be evaluated from stored flags and latched at the DECODE edge; later states use the latch, so a flag update in EXECUTE does not alter its own instruction's writeback.
REQ-030 Latency: data-processing 4, LDR 5, STR 4, branch 3, Op=11 2 cycles.
REQ-031 Failed condition: full state sequence still traversed; MemWrite, RegWrite, branch PCWrite and flags suppressed.

Reset
REQ-032 While reset=0: state=FETCH, Flags=0000, CondEx latch=0, PCWrite/MemWrite/RegWrite/IRWrite forced 0 combinationally, independent of clk; first FETCH occurs in the first cycle after release; reset mid-instruction abandons it with no further writes.

Verification
REQ-033 Reset, Instr=E0821003 -> FETCH,DECODE,EXECUTER,ALUWB; ALUControl=00 in EXECUTER; RegWrite=1 only in ALUWB.
REQ-034 E5912004 -> 5 cycles, AdrSrc=1 in MEMRD, RegWrite=1 in MEMWB; E5812004 -> MemWrite=1 only in MEMWR, 4 cycles.
REQ-035 E2500001 with ALUFlags=0100 in EXECUTEI -> Flags=0100; next 0A000002 -> PCWrite=1 in BRANCH; with Flags=0000 -> PCWrite=0.
REQ-036 Flags=0100, 11500000 (CMPNE) -> no RegWrite, Flags unchanged.
REQ-037 E082F003 -> ALUWB asserts RegWrite=1 and PCWrite=1.
REQ-038 reset driven low during MEMWR between edges -> MemWrite=0 immediately; FETCH after release.
